// File: rtl/offset_decoder.sv
// Offset-code decoder feeding a small FIFO with registered ready/valid control.
// Optional saturating illegal-code counter enabled by OFFSET_DECODER_ERR_CNT_EN.
module offset_decoder #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_data,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [2:0]       mem_q [DEPTH];
  logic [2:0]       entry;
  logic [2:0]       head;
  logic             code_legal;
  logic             push;
  logic             pop;

  // Legal codes are 7..10; subtracting 7 modulo 4 is the same as adding 1.
  always_comb begin
    code_legal = (in_code >= 4'd7) && (in_code <= 4'd10);
    entry      = 3'b001;
    if (code_legal) begin
      entry = {in_code[1:0] + 2'd1, 1'b0};
    end
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_comb begin
    state_d = ST_PARTIAL;
    if (occ_d == '0) begin
      state_d = ST_EMPTY;
    end else if (occ_d == FULL_OCC) begin
      state_d = ST_FULL;
    end
  end

  // Handshake outputs depend on the registered state only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      ST_PARTIAL: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= entry;
    end
  end

  // Asynchronous head read so a word written into an empty FIFO shows the next cycle.
  assign head     = mem_q[rd_ptr_q];
  assign out_data = out_valid ? head[2:1] : 2'b00;
  assign out_err  = out_valid ? head[0]   : 1'b0;

`ifdef OFFSET_DECODER_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && !code_legal && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_offset_decoder.sv
// Self-checking bench for offset_decoder: directed table, corner sequences and
// random traffic compared against a queue-based reference model.
module tb_offset_decoder;

  localparam int DEPTH   = 4;
  localparam int ERR_W   = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef OFFSET_DECODER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_code;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_data;
  logic             out_err;
  logic [ERR_W-1:0] err_count;

  offset_decoder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  bit         started = 1'b0;
  logic [2:0] model_q[$];
  int         model_cnt = 0;

  typedef struct {
    logic [3:0] code;
    logic [1:0] exp_data;
    logic       exp_err;
  } vec_t;

  function automatic logic [2:0] ref_dec(input int c);
    if (c >= 7 && c <= 10) return {2'(c - 7), 1'b0};
    return 3'b001;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] got, exp;
    logic [2:0]  hd;
    hd  = (model_q.size() > 0) ? model_q[0] : 3'b000;
    got = {19'd0, in_ready, out_valid, out_data, out_err, err_count};
    exp = {19'd0, model_q.size() < DEPTH, model_q.size() > 0, hd[2:1], hd[0], ERR_W'(model_cnt)};
    chk("model{rdy,vld,data,err,cnt}", got, exp);
  endtask

  // One clock cycle: drive, check against model, clock, update model.
  task automatic step(input bit rst, input bit v, input logic [3:0] code, input bit rdy);
    bit acc_push, acc_pop;
    logic [2:0] d;
    rst_n = !rst; in_valid = v; in_code = code; out_ready = rdy;
    if (started) check_model();
    acc_push = v && (model_q.size() < DEPTH);
    acc_pop  = rdy && (model_q.size() > 0);
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_cnt = 0;
      started = 1'b1;
    end else begin
      if (acc_pop) void'(model_q.pop_front());
      if (acc_push) begin
        d = ref_dec(int'(code));
        model_q.push_back(d);
        if (d[0] && CNT_EN && model_cnt < ERR_MAX) model_cnt++;
      end
    end
    #1;
  endtask

  initial begin
    vec_t tbl[8];
    int   n;
    tbl[0] = '{4'd7,  2'd0, 1'b0};
    tbl[1] = '{4'd8,  2'd1, 1'b0};
    tbl[2] = '{4'd9,  2'd2, 1'b0};
    tbl[3] = '{4'd10, 2'd3, 1'b0};
    tbl[4] = '{4'd0,  2'd0, 1'b1};
    tbl[5] = '{4'd6,  2'd0, 1'b1};
    tbl[6] = '{4'd11, 2'd0, 1'b1};
    tbl[7] = '{4'd15, 2'd0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_code = 4'd0; out_ready = 1'b0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_state", {in_ready, out_valid, out_data, out_err, err_count}, {1'b1, 1'b0, 2'b00, 1'b0, ERR_W'(0)});

    // Decode table: each word visible right after the edge that accepts it.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, tbl[i].code, 1);
      chk("tbl_valid", out_valid, 1);
      chk("tbl_data_err", {out_data, out_err}, {tbl[i].exp_data, tbl[i].exp_err});
      $display("[TB] code %0d -> data %0d err %0d", tbl[i].code, out_data, out_err);
    end
    step(0, 0, 0, 1);
    chk("err_count_4", err_count, CNT_EN ? 4 : 0);

    // Fill to FULL with a fifth word held off until after a pop.
    for (int i = 0; i < 4; i++) step(0, 1, 4'(7 + i), 0);
    chk("full_in_ready", in_ready, 0);
    step(0, 1, 4'd9, 0);
    chk("full_hold", in_ready, 0);
    step(0, 1, 4'd9, 1);
    chk("after_pop_ready", in_ready, 1);
    step(0, 1, 4'd9, 0);
    chk("fifth_accepted_full", in_ready, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    chk("drained", out_valid, 0);

    // Stream at occupancy 2 across pointer wrap.
    step(0, 1, 4'd7, 0);
    step(0, 1, 4'd8, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 4'($urandom_range(7, 10)), 1);
      chk("stream_hs", {in_ready, out_valid}, 2'b11);
    end
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) n++;
      step(0, 0, 0, 1);
    end
    chk("stream_occ", n, 2);

    // Reset with three entries stored.
    for (int i = 0; i < 3; i++) step(0, 1, 4'd1, 0);
    step(1, 1, 4'd2, 1);
    chk("mid_reset", {in_ready, out_valid, out_data, out_err, err_count}, {1'b1, 1'b0, 2'b00, 1'b0, ERR_W'(0)});
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // Saturation of the illegal-code counter.
    for (int i = 0; i < 300; i++) step(0, 1, 4'd12, 1);
    step(0, 0, 0, 1);
    chk("err_sat", err_count, CNT_EN ? ERR_MAX : 0);
    step(1, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/offset_decoder.md
OFFSET_DECODER -- requirements
Module: offset_decoder

Interface
REQ-001 Parameter: DEPTH, default 4, number of FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter: ERR_W, default 8, width of the error counter.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous and active-low.
REQ-005 Port: in_valid  input  1  in_code holds a word offered for transfer.
REQ-006 Port: in_ready  output  1  block accepts a word this cycle.
REQ-007 Port: in_code  input  4  encoded word, defined as value + 4'b0111, where value is 2 bits.
REQ-008 Port: out_valid  output  1  out_data and out_err hold the FIFO head entry.
REQ-009 Port: out_ready  input  1  downstream consumes the head entry this cycle.
REQ-010 Port: out_data  output  2  decoded value.
REQ-011 Port: out_err  output  1  the head entry came from an illegal code.
REQ-012 Port: err_count  output  ERR_W  saturating count of accepted illegal codes.

Function
REQ-013 A transfer into the block occurs on a rising edge where in_valid=1 and in_ready=1.
REQ-014 A transfer out of the block occurs on a rising edge where out_valid=1 and out_ready=1.
REQ-015 Decoding:
- in_code 7..10 SHALL produce data = in_code - 7 (result truncated to 2 bits) and err = 0.
- Any other in_code SHALL produce data = 2'b00 and err = 1.
REQ-016 The decoded {data, err} pair SHALL be written at the FIFO tail.
- The FIFO uses a write pointer, a read pointer and an occupancy counter (0..DEPTH).
- Both pointers wrap modulo DEPTH.
REQ-017 Control FSM states and their outputs:
- EMPTY (occupancy = 0): out_valid = 0, in_ready = 1.
- PARTIAL (0 < occupancy < DEPTH): out_valid = 1, in_ready = 1.
- FULL (occupancy = DEPTH): out_valid = 1, in_ready = 0.
REQ-018 FSM transitions:
- Push only: occupancy +1.
- Pop only: occupancy -1.
- Push and pop in the same cycle: occupancy unchanged, both pointers advance.
- The state is re-derived from the new occupancy.
REQ-019 in_ready and out_valid SHALL be driven only from registered state; there is no combinational path from in_valid or out_ready.
REQ-020 In FULL, in_ready = 0 even when out_ready = 1; a word is accepted no earlier than the cycle after a pop.
REQ-021 Latency: a word accepted at edge N while EMPTY SHALL be presented with out_valid = 1 after edge N (zero bubble); throughput is 1 word per cycle.
REQ-022 When out_valid = 0, out_data and out_err SHALL be 0.
REQ-023 Ordering SHALL be strictly FIFO.
- No word is dropped or duplicated.
- in_code is ignored when in_ready = 0.

Reset
REQ-024 When rst_n = 0 at a rising edge:
- occupancy and both pointers clear to 0.
- FSM enters EMPTY.
- err_count clears to 0.
- Outputs take in_ready = 1, out_valid = 0, out_data = 0, out_err = 0.
REQ-025 Reset mid-operation SHALL discard all stored entries; no transfer is accepted or emitted on the reset edge.
REQ-026 Stored data RAM contents need no reset.

Configuration
REQ-027 Macro: OFFSET_DECODER_ERR_CNT_EN.
- Defined: err_count increments by 1 on each accepted illegal code and saturates at all-ones.
- Not defined: the counter logic is omitted, and err_count is present and tied to 0.
- out_err behaviour is identical in both builds.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Reset, then push codes 7, 8, 9, 10 with out_ready = 1 -> out_data 0, 1, 2, 3; out_err = 0; each output appears one edge after its input.
- Push codes 0, 6, 11, 15 -> out_data = 0 and out_err = 1 for each; err_count = 4 when the macro is defined, 0 when it is not.
- out_ready = 0 and 5 pushes offered (DEPTH = 4) -> 4 accepted and in_ready = 0 after the 4th; the 5th is held until one pop, then accepted; order is preserved.
- Occupancy 2, with in_valid = 1 and out_ready = 1 for 10 cycles -> occupancy stays 2, 10 words pass in order, and the pointers wrap.
- Occupancy 3, then rst_n = 0 for one edge -> out_valid = 0 and in_ready = 1 the next cycle, no stale data emitted, err_count = 0.
- With the macro defined, 300 illegal codes pushed -> err_count saturates at 255.
